// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences an external AES round datapath through whitening and NUM_ROUNDS rounds
// for one 128-bit block, with key-schedule stalls and sticky protocol-error reporting.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       aes_mode_i,
    input  logic             data_valid_i,
    input  logic [127:0]     aes_data_i,
    input  logic             key_ready_i,
    input  logic [127:0]     rnd_result_i,
    output logic             aes_busy_o,
    output logic [127:0]     rnd_state_o,
    output logic [IDX_W-1:0] rnd_idx_o,
    output logic             rnd_dec_o,
    output logic             rnd_init_o,
    output logic             rnd_final_o,
    output logic [127:0]     result_o,
    output logic             result_valid_o,
    output logic             error_o
);
    localparam logic [IDX_W-1:0] NR = IDX_W'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] s_q, s_d;
    logic [127:0]     data_q, data_d, result_q, result_d;
    logic             dec_q, dec_d, err_q, err_d, busy_q, rv_q;
    logic             run, last, accept;

    always_comb begin
        run      = state_q == RUN;
        last     = s_q == NR;
        accept   = !run && data_valid_i && aes_mode_i[1];
        state_d  = state_q;
        s_d      = s_q;
        data_d   = data_q;
        result_d = result_q;
        dec_d    = dec_q;
        // a strobe while busy, or the reserved mode, is a protocol error
        err_d    = err_q | (data_valid_i && (run || aes_mode_i == 2'b01));
        if (run) begin
            if (key_ready_i) begin
                data_d = rnd_result_i;
                s_d    = s_q + 1'b1;
                if (last) begin
                    state_d  = DONE;
                    result_d = rnd_result_i;
                    s_d      = '0;
                end
            end
        end else begin
            state_d = accept ? RUN : IDLE;
            if (accept) begin
                data_d = aes_data_i;
                dec_d  = aes_mode_i[0];
                s_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= '0;
            data_q   <= '0;
            result_q <= '0;
            dec_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            data_q   <= data_d;
            result_q <= result_d;
            dec_q    <= dec_d;
            err_q    <= err_d;
            busy_q   <= state_d == RUN;
            rv_q     <= state_d == DONE;
        end
    end

    assign aes_busy_o     = busy_q;
    assign rnd_state_o    = data_q;
    assign rnd_dec_o      = dec_q;
    assign result_o       = result_q;
    assign result_valid_o = rv_q;
    assign error_o        = err_q;
    assign rnd_idx_o      = run ? (dec_q ? NR - s_q : s_q) : '0;
    assign rnd_init_o     = run && s_q == '0;
    assign rnd_final_o    = run && last;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: drives aes_round_ctrl with a stub datapath and a behavioural AES-128 round,
// comparing against expectations derived from the block's sequencing rules and FIPS-197.
module tb_aes_round_ctrl;
    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   aes_mode;
    logic         data_valid, key_ready;
    logic [127:0] aes_data, rnd_result;
    logic         aes_busy, rnd_dec, rnd_init, rnd_final, result_valid, error;
    logic [127:0] rnd_state, result;
    logic [3:0]   rnd_idx;

    int  tests = 0, fails = 0;
    bit  use_aes = 1'b0;
    logic [7:0]   sbox [256];
    logic [7:0]   isbox[256];
    logic [127:0] rk   [0:10];
    logic [127:0] stub_x;

    aes_round_ctrl #(.NUM_ROUNDS(NR), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .aes_mode_i(aes_mode), .data_valid_i(data_valid),
        .aes_data_i(aes_data), .key_ready_i(key_ready), .rnd_result_i(rnd_result),
        .aes_busy_o(aes_busy), .rnd_state_o(rnd_state), .rnd_idx_o(rnd_idx),
        .rnd_dec_o(rnd_dec), .rnd_init_o(rnd_init), .rnd_final_o(rnd_final),
        .result_o(result), .result_valid_o(result_valid), .error_o(error)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xtime(a);
        end
        return p;
    endfunction

    function automatic logic [127:0] mixcols(logic [127:0] x, bit inv);
        logic [7:0]   k[4];
        logic [7:0]   o;
        logic [127:0] y;
        if (inv) begin k[0] = 8'd14; k[1] = 8'd11; k[2] = 8'd13; k[3] = 8'd9; end
        else     begin k[0] = 8'd2;  k[1] = 8'd3;  k[2] = 8'd1;  k[3] = 8'd1; end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                o = 8'h00;
                for (int j = 0; j < 4; j++) o ^= gmul(k[(j - r + 4) % 4], x[127-8*(4*c+j) -: 8]);
                y[127-8*(4*c+r) -: 8] = o;
            end
        return y;
    endfunction

    // One datapath step: forward cipher round or straight inverse cipher round.
    function automatic logic [127:0] aes_step(logic [127:0] s, logic [3:0] idx, logic dec, logic init, logic fin);
        logic [127:0] t;
        if (init) return s ^ rk[idx];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(4*c+r) -: 8] = dec ? isbox[s[127-8*(4*((c-r+4)%4)+r) -: 8]]
                                            : sbox[s[127-8*(4*((c+r)%4)+r) -: 8]];
        if (dec) begin
            t ^= rk[idx];
            return fin ? t : mixcols(t, 1'b1);
        end
        return (fin ? t : mixcols(t, 1'b0)) ^ rk[idx];
    endfunction

    assign rnd_result = use_aes ? aes_step(rnd_state, rnd_idx, rnd_dec, rnd_init, rnd_final)
                                : rnd_state ^ {124'd0, rnd_idx};

    task automatic keyexp(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one block from its strobe to the result_valid cycle, checking the step sequence on the way.
    task automatic op(input logic [1:0] mode, input logic [127:0] din, input int sa, input int sb,
                      input bit rs, input int strobe_at, output logic [127:0] res, output int lat);
        int k = 0, st0 = 0, st5 = 0, busy_n = 0, stalls = 0;
        bit dec = mode[0];
        bit kr;
        aes_mode = mode; aes_data = din; data_valid = 1'b1; key_ready = 1'b1;
        tick();
        lat = 1;
        chk("busy_t1", aes_busy, 1);
        while (!result_valid && lat < 200) begin
            data_valid = (lat == strobe_at);
            aes_data   = {4{$urandom}};
            aes_mode   = data_valid ? 2'b10 : 2'($urandom);
            if (aes_busy) busy_n++;
            chk("idx", rnd_idx, dec ? NR - k : k);
            chk("init", rnd_init, k == 0);
            chk("final", rnd_final, k == NR);
            chk("dec", rnd_dec, dec);
            kr = 1'b1;
            if (k == 0 && st0 < sa) begin kr = 1'b0; st0++; end
            else if (k == 5 && st5 < sb) begin kr = 1'b0; st5++; end
            else if (rs && $urandom_range(3) == 0) kr = 1'b0;
            key_ready = kr;
            if (kr) k++; else stalls++;
            tick();
            lat++;
        end
        data_valid = 1'b0; key_ready = 1'b1; aes_mode = 2'b00;
        chk("result_valid", result_valid, 1);
        chk("busy_at_done", aes_busy, 0);
        chk("latency", lat, 12 + stalls);
        chk("busy_cycles", busy_n, 11 + stalls);
        chk("steps", k, NR + 1);
        res = result;
    endtask

    initial begin
        logic [127:0] d, res, res2, pt, ct;
        logic [7:0]   inv, b;
        int           lat, lat2, bad;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
            b = inv;
            for (int i = 0; i < 4; i++) begin
                b = {b[6:0], b[7]};
                inv ^= b;
            end
            sbox[x] = inv ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
        stub_x = '0;
        for (int r = 0; r <= NR; r++) stub_x ^= 128'(r);

        rst = 1'b1; data_valid = 1'b0; key_ready = 1'b1; aes_mode = 2'b00; aes_data = '0;
        tick(); tick();
        chk("rst_busy", aes_busy, 0);      chk("rst_rv", result_valid, 0);
        chk("rst_error", error, 0);        chk("rst_dec", rnd_dec, 0);
        chk("rst_init", rnd_init, 0);      chk("rst_final", rnd_final, 0);
        chk("rst_idx", rnd_idx, 0);        chk("rst_state", rnd_state, 0);
        chk("rst_result", result, 0);
        rst = 1'b0;
        tick();

        op(2'b10, '0, 0, 0, 0, -1, res, lat);
        chk("enc_stub", res, 128'hB);
        tick();
        chk("rv_pulse", result_valid, 0);
        chk("idle_busy", aes_busy, 0);
        chk("idle_idx", rnd_idx, 0);
        op(2'b11, '0, 0, 0, 0, -1, res, lat);
        chk("dec_stub", res, 128'hB);
        tick();

        for (int i = 0; i < 6; i++) begin
            d = {4{$urandom}};
            op({1'b1, 1'($urandom)}, d, 0, 0, 1, -1, res, lat);
            chk("rand_stub", res, d ^ stub_x);
            repeat ($urandom_range(2)) tick();
        end
        chk("no_error", error, 0);

        d = {4{$urandom}};
        op(2'b10, d, 3, 2, 0, -1, res, lat);
        chk("stall_lat", lat, 17);
        chk("stall_res", res, d ^ stub_x);
        tick();

        data_valid = 1'b1; aes_mode = 2'b00; aes_data = {4{$urandom}};
        tick();
        data_valid = 1'b0;
        chk("mode00_busy", aes_busy, 0);
        tick();
        chk("mode00_busy2", aes_busy, 0);
        chk("mode00_error", error, 0);

        use_aes = 1'b1;
        keyexp(128'h000102030405060708090a0b0c0d0e0f);
        op(2'b10, 128'h00112233445566778899aabbccddeeff, 0, 0, 0, -1, ct, lat);
        chk("fips_enc", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        tick();
        op(2'b11, ct, 0, 0, 1, -1, pt, lat);
        chk("fips_dec", pt, 128'h00112233445566778899aabbccddeeff);
        keyexp({4{$urandom}});
        for (int i = 0; i < 3; i++) begin
            d = {4{$urandom}};
            op(2'b10, d, 0, 0, 1, -1, ct, lat);
            tick();
            op(2'b11, ct, 1, 1, 1, -1, pt, lat);
            chk("aes_roundtrip", pt, d);
            tick();
        end
        use_aes = 1'b0;

        data_valid = 1'b1; aes_mode = 2'b01; aes_data = {4{$urandom}};
        tick();
        data_valid = 1'b0; aes_mode = 2'b00;
        chk("mode01_error", error, 1);
        chk("mode01_busy", aes_busy, 0);
        tick();

        d = {4{$urandom}};
        op(2'b10, d, 0, 0, 0, 4, res, lat);
        chk("midrun_res", res, d ^ stub_x);
        chk("sticky_error", error, 1);
        tick();

        d = {4{$urandom}};
        op(2'b10, d, 0, 0, 0, -1, res, lat);
        pt = {4{$urandom}};
        op(2'b11, pt, 0, 0, 0, -1, res2, lat2);
        chk("b2b_first", res, d ^ stub_x);
        chk("b2b_second", res2, pt ^ stub_x);
        chk("b2b_gap", lat2, 12);
        tick();

        data_valid = 1'b1; aes_mode = 2'b10; aes_data = {4{$urandom}};
        tick();
        data_valid = 1'b0;
        repeat (4) tick();
        chk("pre_rst_idx", rnd_idx, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", aes_busy, 0);     chk("mrst_rv", result_valid, 0);
        chk("mrst_error", error, 0);       chk("mrst_dec", rnd_dec, 0);
        chk("mrst_init", rnd_init, 0);     chk("mrst_final", rnd_final, 0);
        chk("mrst_idx", rnd_idx, 0);       chk("mrst_state", rnd_state, 0);
        chk("mrst_result", result, 0);
        bad = 0;
        repeat (20) begin
            tick();
            if (result_valid || aes_busy) bad++;
        end
        chk("no_rv_after_rst", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

AES engine-side responder for the storage control unit's 128-bit block handshake. It accepts a block on `data_valid` under `aes_mode` (`10` encrypt, `11` decrypt). It holds `aes_busy` while it sequences an external combinational round datapath through the whitening step and `NUM_ROUNDS` rounds, then presents the result with a one-cycle `result_valid` pulse. It owns all sequencing, round-key indexing, stall and error handling; the round logic and key schedule sit outside it.

## Interface
- `NUM_ROUNDS`, 10: number of full rounds after whitening (AES-128 = 10).
- `IDX_W`, 4: width of the round-key index; must hold `NUM_ROUNDS`.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `aes_mode`  in  2  `00` idle, `10` encrypt, `11` decrypt, `01` illegal.
- `data_valid`  in  1  one-cycle strobe; `aes_data` is valid this cycle.
- `aes_data`  in  128  input block.
- `key_ready`  in  1  key schedule can supply the key for `rnd_idx` this cycle.
- `rnd_result`  in  128  datapath output for the current step (combinational from `rnd_*`).
- `aes_busy`  out  1  operation in flight.
- `rnd_state`  out  128  current working state to the datapath.
- `rnd_idx`  out  IDX_W  round-key index for the current step.
- `rnd_dec`  out  1  latched mode: 1 decrypt, 0 encrypt.
- `rnd_init`  out  1  whitening step (AddRoundKey only).
- `rnd_final`  out  1  last round (no MixColumns / InvMixColumns).
- `result`  out  128  final block; held until the next completion or reset.
- `result_valid`  out  1  one-cycle pulse; `result` is valid.
- `error`  out  1  sticky protocol error.

## Operation
- States:
  - IDLE.
  - RUN: step counter `s` runs 0..NUM_ROUNDS.
  - DONE.
- Acceptance in IDLE or DONE, when `data_valid=1`:
  - `aes_mode` `10`/`11`: latch `aes_data` into the state register, latch `rnd_dec = aes_mode[0]`, set `s=0`, go to RUN.
  - `aes_mode` `00`: the strobe is ignored, no error.
  - `aes_mode` `01`: the strobe is ignored and `error` is set.
- RUN, per cycle:
  - Drive `rnd_state` from the state register.
  - `rnd_idx = s` for encrypt; `rnd_idx = NUM_ROUNDS - s` for decrypt.
  - `rnd_init = (s==0)`; `rnd_final = (s==NUM_ROUNDS)`.
  - If `key_ready=1`: state register <= `rnd_result`, then `s++`. If `s` was `NUM_ROUNDS`, go to DONE.
  - If `key_ready=0`: stall. Everything is held and `aes_busy` stays high.
- DONE, one cycle:
  - `result` is taken from the state register; `result_valid=1`, `aes_busy=0`.
  - Next state is RUN if a new block is accepted this cycle, otherwise IDLE.
- `data_valid` during RUN: ignored, `error` set, the operation continues unaffected.
- `aes_mode` changes during RUN are ignored; the latched mode is used.
- `error` clears only on reset.
- Outside RUN, `rnd_init`, `rnd_final` and `rnd_idx` are 0.

## Timing
- Reset values:
  - state IDLE, `s=0`.
  - `aes_busy`, `result_valid`, `error`, `rnd_dec`, `rnd_init`, `rnd_final` = 0.
  - `rnd_idx` = 0; `rnd_state`, `result` = 0.
- Reset mid-operation discards the block. No `result_valid` is produced for it.
- Outputs are registered, except `rnd_idx`, `rnd_init` and `rnd_final`, which decode from registered state and `s`.
- Latency with no stalls: strobe sampled in cycle T.
  - `aes_busy=1` during cycles T+1 .. T+1+NUM_ROUNDS, i.e. 11 cycles for AES-128.
  - `result_valid=1` and `aes_busy=0` in cycle T+2+NUM_ROUNDS.
  - Each stall cycle adds exactly one cycle.
- `aes_busy` is guaranteed high one cycle after the accepted strobe. A controller that checks busy two cycles after its strobe therefore never misses the operation.
- Back-to-back: a strobe in the DONE cycle is accepted. `aes_busy` rises the next cycle, giving a gapless restart.
- `result_valid` never coincides with `aes_busy=1`.

## Test plan
- **Datapath stub, encrypt.** Stub: `rnd_result = rnd_state ^ rnd_idx`. Encrypt with `aes_data=0` and `key_ready=1` -> `rnd_idx` sequence 0,1,..,10 with `rnd_init` on idx 0 and `rnd_final` on idx 10. `result=128'hB`; busy high exactly 11 cycles; `result_valid` at T+12.
- **Datapath stub, decrypt.** Same stub, decrypt -> `rnd_idx` sequence 10,9,..,0. `rnd_init` on the first step (idx 10), `rnd_final` on the last (idx 0), `rnd_dec=1`, `result=128'hB`.
- **Real datapath, FIPS-197.** Key `000102030405060708090a0b0c0d0e0f`. Encrypt `00112233445566778899aabbccddeeff` -> `69c4e0d86a7b0430d8cdb78070b4c55a`. Decrypting that block returns the plaintext.
- **Key stalls.** Drop `key_ready` for 3 cycles at s=0 and 2 cycles at s=5 -> `result_valid` at T+17, result unchanged versus the no-stall run.
- **Protocol errors.** A strobe mid-RUN and a strobe with `aes_mode=01` in IDLE -> `error` rises and stays high, and the in-flight result is correct. A strobe with `aes_mode=00` -> no error, no busy.
- **Back-to-back and reset.** Two blocks with the second strobe in the DONE cycle -> two `result_valid` pulses 12 cycles apart. `rst` at s=4 -> all outputs return to reset values next cycle, and no `result_valid` follows.
